// File: rtl/lx32_muldiv_if.sv
// ============================================================================
// Module   : lx32_muldiv_if
// Brief    : Request/result handshake bundle for the lx32 multiply/divide unit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface lx32_muldiv_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_result, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_result, out_tag
    );
endinterface

`default_nettype wire

// File: rtl/lx32_muldiv.sv
// ============================================================================
// Module   : lx32_muldiv
// Brief    : Iterative RV32M multiply/divide, one bit per cycle, tagged result.
//            Optional LX32_MULDIV_FASTPATH_EN short-circuits trivial operations.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module lx32_muldiv #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    lx32_muldiv_if.slave bus,
    output logic         busy
);
    localparam int c_cnt_w = $clog2(WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic [TAG_W-1:0]   tag_q, tag_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d, b_q, b_d, result_q, result_d;
    logic [c_cnt_w-1:0] cnt_q, cnt_d;
    logic               neg_q, neg_d, negr_q, negr_d, fast_q, fast_d;

    logic               w_a_signed, w_b_signed, w_a_neg, w_b_neg, w_b_zero;
    logic [WIDTH-1:0]   w_mag_a, w_mag_b;

    assign w_a_signed = (bus.in_op == 3'd1) || (bus.in_op == 3'd2) ||
                        (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
    assign w_b_signed = (bus.in_op == 3'd1) || (bus.in_op == 3'd4) || (bus.in_op == 3'd6);
    assign w_a_neg    = w_a_signed & bus.in_a[WIDTH-1];
    assign w_b_neg    = w_b_signed & bus.in_b[WIDTH-1];
    assign w_mag_a    = w_a_neg ? -bus.in_a : bus.in_a;
    assign w_mag_b    = w_b_neg ? -bus.in_b : bus.in_b;
    assign w_b_zero   = (bus.in_b == '0);

    logic             w_fast_hit;
    logic [WIDTH-1:0] w_fast_val;

`ifdef LX32_MULDIV_FASTPATH_EN
    logic w_ovf;
    assign w_ovf = ((bus.in_op == 3'd4) || (bus.in_op == 3'd6)) &&
                   (bus.in_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.in_b);

    always_comb begin
        w_fast_hit = 1'b0;
        w_fast_val = '0;
        if (bus.in_op[2] && w_b_zero) begin
            w_fast_hit = 1'b1;
            w_fast_val = bus.in_op[1] ? bus.in_a : '1;
        end else if (w_ovf) begin
            w_fast_hit = 1'b1;
            w_fast_val = bus.in_op[1] ? '0 : bus.in_a;
        end else if (!bus.in_op[2] && ((bus.in_a == '0) || w_b_zero)) begin
            w_fast_hit = 1'b1;
        end
    end
`else
    assign w_fast_hit = 1'b0;
    assign w_fast_val = '0;
`endif

    // hi/lo double as product accumulator/multiplier and remainder/quotient.
    logic [WIDTH:0]   w_mul_sum, w_div_tmp;
    logic [WIDTH+1:0] w_div_diff;

    assign w_mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
    assign w_div_tmp  = {hi_q, lo_q[WIDTH-1]};
    assign w_div_diff = {1'b0, w_div_tmp} - {2'b00, b_q};

    logic [2*WIDTH-1:0] w_prod;
    logic [WIDTH-1:0]   w_quo, w_rem, w_fix_val;

    assign w_prod = neg_q  ? -{hi_q, lo_q} : {hi_q, lo_q};
    assign w_quo  = neg_q  ? -lo_q : lo_q;
    assign w_rem  = negr_q ? -hi_q : hi_q;

    always_comb begin
        w_fix_val = w_rem;
        case (op_q)
            3'd0:                w_fix_val = w_prod[WIDTH-1:0];
            3'd1, 3'd2, 3'd3:    w_fix_val = w_prod[2*WIDTH-1:WIDTH];
            3'd4, 3'd5:          w_fix_val = w_quo;
            default:             w_fix_val = w_rem;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        tag_d    = tag_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        fast_d   = fast_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    op_d   = bus.in_op;
                    tag_d  = bus.in_tag;
                    hi_d   = '0;
                    lo_d   = w_mag_a;
                    b_d    = w_mag_b;
                    cnt_d  = '0;
                    // A zero divisor keeps the all-ones quotient unsigned.
                    neg_d  = (w_a_neg ^ w_b_neg) & ~w_b_zero;
                    negr_d = w_a_neg;
                    fast_d = w_fast_hit;
                    if (w_fast_hit) begin
                        result_d = w_fast_val;
                        state_d  = ST_FIX;
                    end else begin
                        state_d  = ST_CALC;
                    end
                end
            end
            ST_CALC: begin
                if (op_q[2]) begin
                    hi_d = w_div_diff[WIDTH+1] ? w_div_tmp[WIDTH-1:0] : w_div_diff[WIDTH-1:0];
                    lo_d = {lo_q[WIDTH-2:0], ~w_div_diff[WIDTH+1]};
                end else begin
                    hi_d = w_mul_sum[WIDTH:1];
                    lo_d = {w_mul_sum[0], lo_q[WIDTH-1:1]};
                end
                cnt_d = cnt_q + c_cnt_w'(1);
                if (cnt_q == c_cnt_w'(WIDTH-1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                if (!fast_q) begin
                    result_d = w_fix_val;
                end
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            op_q     <= '0;
            tag_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            fast_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            tag_q    <= tag_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            fast_q   <= fast_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready   = (state_q == ST_IDLE);
    assign bus.out_valid  = (state_q == ST_DONE);
    assign bus.out_result = result_q;
    assign bus.out_tag    = tag_q;
    assign busy           = (state_q != ST_IDLE);
endmodule

`default_nettype wire
